mem_byte_bridge: RTL and testbench
==================================

// Module: mem_byte_bridge
// PURPOSE
//  Upstream neighbour of the byte-wide ram: turns one CPU load/store of 1/2/4/8 bytes
//  into a sequence of single-byte accesses with separate re/we strobe pulses.
//  Little-endian byte order, ascending address order. Load results can be zero- or
//  sign-extended to 64 bits. Sits between the MIPS64 LSU and ram.
// PARAMETERS
//  MADDR_SZ  32  byte address width; must match ram MADDR_SZ
//  DATA_W    64  CPU data width; fixed at 64, size codes cover up to 8 bytes
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         asynchronous, active-high reset
//  req_valid   in   1         request present
//  req_ready   out  1         bridge can accept; 1 only in IDLE
//  req_we      in   1         1=store, 0=load
//  req_size    in   2         00=1B 01=2B 10=4B 11=8B
//  req_signed  in   1         load only: 1=sign-extend, 0=zero-extend
//  req_addr    in   MADDR_SZ  byte address of lowest byte
//  req_wdata   in   DATA_W    store data, byte k = wdata[8k+7:8k]
//  resp_valid  out  1         response/ack; held until resp_ready
//  resp_ready  in   1         consumer accepts response
//  resp_rdata  out  DATA_W    extended load data; 0 for stores
//  resp_err    out  1         misaligned request (MEMB_ALIGN_CHECK_EN only, else 0)
//  ram_raddr   out  MADDR_SZ  to ram raddr
//  ram_waddr   out  MADDR_SZ  to ram waddr
//  ram_datain  out  8         to ram datain
//  ram_dataout in   8         from ram dataout
//  ram_re      out  1         read strobe; ram acts on its rising edge
//  ram_we      out  1         write strobe; ram acts on its rising edge
// BEHAVIOUR
//  Reset (async): state=IDLE, req_ready=1 next, resp_valid=0, resp_rdata=0, resp_err=0,
//   ram_re=ram_we=0, ram_raddr=ram_waddr=0, ram_datain=0, byte counter=0.
//  Accept: req_valid&&req_ready at a rising edge latches the request; N=1<<req_size.
//  FSM: IDLE -> SETUP -> STROBE -> (load: CAPTURE) -> SETUP (next byte) | RESP.
//   SETUP:   addr = base+k (mod 2^MADDR_SZ); ram_datain = wdata byte k; strobes 0.
//   STROBE:  ram_re (load) or ram_we (store) =1 for exactly one cycle; addr/data stable.
//   CAPTURE: strobes 0; ram_dataout -> byte lane k; k++.
//   Store: k++ on leaving STROBE.
//   RESP:    resp_valid=1, outputs stable until resp_ready sampled 1, then IDLE.
//  Latency accept->resp_valid: load 3N+1 cycles, store 2N+1 cycles.
//  Strobes are never 1 in consecutive cycles, so every byte gets its own rising edge.
//  Only one strobe is active at a time; addr/datain never change while a strobe is 1.
//  Extension: load of N<8 bytes, bits above 8N = sign bit of top byte if req_signed,
//   else 0. req_signed is ignored for N=8.
//  Address wrap: base+k past 2^MADDR_SZ-1 wraps to 0; no error.
//  Ordering: bytes strictly ascending, so MMIO trigger bytes at high addresses are
//   written last (e.g. 4B store at 0x205 completes with byte 0x208).
//  req_* ignored while not IDLE; resp_ready ignored outside RESP.
//  Reset mid-operation: strobes drop immediately, no further ram accesses, partial
//   store bytes stay written, no response issued.
// CONFIGURATION
//  MEMB_ALIGN_CHECK_EN defined: req_addr not multiple of N -> no ram access;
//   IDLE->RESP directly, resp_err=1, resp_rdata=0, latency 1 cycle.
//  Not defined: any alignment allowed, resp_err tied 0.
// TESTING
//  8B store 0x1122334455667788 @0x10 -> bytes 0x88..0x11 at 0x10..0x17, 8 we pulses,
//   resp_valid at +17.
//  4B signed load @0x10 -> resp_rdata=0x0000000055667788; preload 0x80 @0x13 ->
//   0xFFFFFFFF80667788. Unsigned load -> 0x0000000080667788. resp_valid at +13.
//  Hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0; then IDLE.
//  2B load @0xFFFFFFFF (check off) -> reads 0xFFFFFFFF then 0x00000000.
//  Assert rst during 3rd STROBE of 8B store -> strobes 0 same cycle, bytes 0..1 written
//   (byte 2 if its edge already occurred), no resp.
//  MEMB_ALIGN_CHECK_EN: 4B load @0x2 -> resp_err=1 next cycle, ram_re never pulses.

Source files
------------

// File: rtl/mem_byte_bridge.sv
// ============================================================================
// Module  : mem_byte_bridge
// Brief   : Splits a 1/2/4/8-byte CPU load/store into ascending single-byte
//           ram accesses with one-cycle re/we strobes. Optional alignment
//           check enabled by defining MEMB_ALIGN_CHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_byte_bridge #(
    parameter int MADDR_SZ = 32,
    parameter int DATA_W   = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    input  logic [MADDR_SZ-1:0] req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [MADDR_SZ-1:0] ram_raddr,
    output logic [MADDR_SZ-1:0] ram_waddr,
    output logic [7:0]          ram_datain,
    input  logic [7:0]          ram_dataout,
    output logic                ram_re,
    output logic                ram_we
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_we;
    logic                  r_signed;
    logic [1:0]            r_size;
    logic [MADDR_SZ-1:0]   r_base;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rbuf;
    logic [2:0]            r_k;

    logic [2:0]            w_kmax;
    logic [2:0]            w_knext;
    logic                  w_last;
    logic [MADDR_SZ-1:0]   w_addr_next;
    logic [7:0]            w_byte_next;
    logic [DATA_W-1:0]     w_rbuf;

    assign w_kmax      = 3'((4'd1 << r_size) - 4'd1);
    assign w_last      = (r_k == w_kmax);
    assign w_knext     = r_k + 3'd1;
    assign w_addr_next = r_base + MADDR_SZ'(w_knext);
    assign w_byte_next = r_wdata[8*w_knext +: 8];

    // Load buffer with the byte currently on ram_dataout merged into lane k.
    always_comb begin
        w_rbuf              = r_rbuf;
        w_rbuf[8*r_k +: 8]  = ram_dataout;
    end

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] sz,
                                                 input logic sgn);
        logic [DATA_W-1:0] r;
        r = d;
        case (sz)
            2'd0:    r = {{56{sgn & d[7]}},  d[7:0]};
            2'd1:    r = {{48{sgn & d[15]}}, d[15:0]};
            2'd2:    r = {{32{sgn & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef MEMB_ALIGN_CHECK_EN
    logic [2:0] w_amask;
    logic       w_misalign;
    assign w_amask    = 3'((4'd1 << req_size) - 4'd1);
    assign w_misalign = |(req_addr[2:0] & w_amask);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'd0;
            r_base     <= '0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
            r_k        <= 3'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            ram_raddr  <= '0;
            ram_waddr  <= '0;
            ram_datain <= 8'd0;
            ram_re     <= 1'b0;
            ram_we     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_signed  <= req_signed;
                        r_size    <= req_size;
                        r_base    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_rbuf    <= '0;
                        r_k       <= 3'd0;
                        req_ready <= 1'b0;
`ifdef MEMB_ALIGN_CHECK_EN
                        if (w_misalign) begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else
`endif
                        begin
                            r_state    <= S_SETUP;
                            ram_raddr  <= req_addr;
                            ram_waddr  <= req_addr;
                            ram_datain <= req_wdata[7:0];
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_STROBE;
                    if (r_we) ram_we <= 1'b1;
                    else      ram_re <= 1'b1;
                end
                S_STROBE: begin
                    ram_re <= 1'b0;
                    ram_we <= 1'b0;
                    if (!r_we) begin
                        r_state <= S_CAPTURE;
                    end else if (w_last) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        r_state    <= S_SETUP;
                        r_k        <= w_knext;
                        ram_waddr  <= w_addr_next;
                        ram_raddr  <= w_addr_next;
                        ram_datain <= w_byte_next;
                    end
                end
                S_CAPTURE: begin
                    r_rbuf <= w_rbuf;
                    if (w_last) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= extend(w_rbuf, r_size, r_signed);
                    end else begin
                        r_state    <= S_SETUP;
                        r_k        <= w_knext;
                        ram_waddr  <= w_addr_next;
                        ram_raddr  <= w_addr_next;
                        ram_datain <= w_byte_next;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state    <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_byte_bridge.sv
// ============================================================================
// Module  : tb_mem_byte_bridge
// Brief   : Scoreboard bench for mem_byte_bridge with a byte-wide ram model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_byte_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_raddr;
    logic [31:0] ram_waddr;
    logic [7:0]  ram_datain;
    logic [7:0]  ram_dataout;
    logic        ram_re;
    logic        ram_we;

    mem_byte_bridge #(.MADDR_SZ(32), .DATA_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_datain(ram_datain),
        .ram_dataout(ram_dataout), .ram_re(ram_re), .ram_we(ram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-wide ram model: 4 KiB window, address bits above 11 ignored.
    logic [7:0]  mem [0:4095];
    int          we_cnt = 0;
    int          re_cnt = 0;
    logic [31:0] last_waddr;
    logic [31:0] rd_addrs [$];

    always @(posedge ram_we) begin
        mem[ram_waddr[11:0]] = ram_datain;
        last_waddr = ram_waddr;
        we_cnt++;
    end

    always @(posedge ram_re) begin
        ram_dataout = mem[ram_raddr[11:0]];
        rd_addrs.push_back(ram_raddr);
        re_cnt++;
    end

    // Strobe protocol: never both, never high on two consecutive cycles.
    int   viol = 0;
    logic p_re = 1'b0;
    logic p_we = 1'b0;
    always @(negedge clk) begin
        if ((ram_re && ram_we) || (ram_re && p_re) || (ram_we && p_we)) viol++;
        p_re = ram_re;
        p_we = ram_we;
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb [$];

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int hold);
        int   n;
        exp_t e;
        sb.push_back('{rdata: exp_rdata, err: exp_err});
        @(posedge clk); #1;
        check_val("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        // Scramble request fields: they must be ignored while busy.
        req_valid = 1'b0; req_addr = $urandom; req_wdata = {$urandom, $urandom};
        req_we = 1'($urandom); req_size = 2'($urandom);
        n = 0;
        while (!resp_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        if (!resp_valid) begin
            check_val("resp_timeout", 64'(resp_valid), 64'd1);
            return;
        end
        check_val("latency", 64'(n + 1), 64'(exp_lat));
        check_val("resp_rdata", resp_rdata, e.rdata);
        check_val("resp_err", 64'(resp_err), 64'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_valid", 64'(resp_valid), 64'd1);
            check_val("hold_rdata", resp_rdata, e.rdata);
            check_val("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_val("resp_drop", 64'(resp_valid), 64'd0);
        check_val("req_ready_back", 64'(req_ready), 64'd1);
    endtask

    function automatic logic [63:0] mem64(input int base);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[(base + i) & 12'hFFF];
        return v;
    endfunction

    initial begin
        int c0;
        int n;
        logic saw_resp;
        for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        ram_dataout = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_req_ready", 64'(req_ready), 64'd1);
        check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_val("rst_resp_rdata", resp_rdata, 64'd0);
        check_val("rst_strobes", {62'd0, ram_re, ram_we}, 64'd0);
        check_val("rst_addr", {ram_raddr, ram_waddr}, 64'd0);
        rst = 1'b0;

        // 8-byte store, ascending little-endian
        c0 = we_cnt;
        do_req(1'b1, 2'd3, 1'b0, 32'h10, 64'h1122334455667788, 64'd0, 1'b0, 17, 0);
        check_val("st8_pulses", 64'(we_cnt - c0), 64'd8);
        check_val("st8_mem", mem64(32'h10), 64'h1122334455667788);

        do_req(1'b0, 2'd2, 1'b1, 32'h10, '0, 64'h0000000055667788, 1'b0, 13, 0);
        mem[12'h13] = 8'h80;
        do_req(1'b0, 2'd2, 1'b1, 32'h10, '0, 64'hFFFFFFFF80667788, 1'b0, 13, 5);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, '0, 64'h0000000080667788, 1'b0, 13, 0);
        do_req(1'b0, 2'd0, 1'b1, 32'h13, '0, 64'hFFFFFFFFFFFFFF80, 1'b0, 4, 0);
        do_req(1'b0, 2'd1, 1'b0, 32'h11, '0, 64'h0000000000006677, 1'b0, 7, 0);
        do_req(1'b0, 2'd3, 1'b1, 32'h10, '0, 64'h1122334480667788, 1'b0, 25, 0);

`ifdef MEMB_ALIGN_CHECK_EN
        c0 = re_cnt;
        do_req(1'b0, 2'd2, 1'b0, 32'h2, '0, 64'd0, 1'b1, 1, 0);
        check_val("align_no_re", 64'(re_cnt - c0), 64'd0);
        c0 = we_cnt;
        do_req(1'b1, 2'd1, 1'b0, 32'h21, 64'hFFFF, 64'd0, 1'b1, 1, 0);
        check_val("align_no_we", 64'(we_cnt - c0), 64'd0);
`else
        // Address wrap
        mem[12'hFFF] = 8'hAB; mem[12'h000] = 8'hCD;
        rd_addrs.delete();
        do_req(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, '0, 64'h000000000000CDAB, 1'b0, 7, 0);
        check_val("wrap_nreads", 64'(rd_addrs.size()), 64'd2);
        if (rd_addrs.size() == 2) begin
            check_val("wrap_addr0", 64'(rd_addrs[0]), 64'hFFFFFFFF);
            check_val("wrap_addr1", 64'(rd_addrs[1]), 64'h0);
        end
        // Misaligned store completes with highest byte last
        do_req(1'b1, 2'd2, 1'b0, 32'h205, 64'h00000000DEADBEEF, 64'd0, 1'b0, 9, 0);
        check_val("st4_last_addr", 64'(last_waddr), 64'h208);
        check_val("st4_mem", mem64(32'h205) & 64'hFFFFFFFF, 64'hDEADBEEF);
`endif

        // Reset during the third write strobe of an 8-byte store
        c0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_signed = 1'b0;
        req_addr = 32'h40; req_wdata = 64'h0807060504030201;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!(ram_we && we_cnt == c0 + 3) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("mid_reach_strobe3", 64'(ram_we && we_cnt == c0 + 3), 64'd1);
        rst = 1'b1;
        #1;
        check_val("mid_strobes_drop", {62'd0, ram_re, ram_we}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        saw_resp = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (resp_valid) saw_resp = 1'b1;
        end
        check_val("mid_no_resp", 64'(saw_resp), 64'd0);
        check_val("mid_pulses", 64'(we_cnt - c0), 64'd3);
        check_val("mid_mem", mem64(32'h40), 64'h0000000000030201);
        check_val("mid_req_ready", 64'(req_ready), 64'd1);

        // Bridge still works after a mid-operation reset
        do_req(1'b0, 2'd1, 1'b1, 32'h41, '0, 64'h0000000000000302, 1'b0, 7, 0);

        check_val("strobe_protocol", 64'(viol), 64'd0);
        check_val("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
